// File: rtl/apb_master.sv
// APB initiator: queues commands in a small FIFO and issues them in order as
// zero-wait-state APB transfers, returning a one-cycle response per transfer.
module apb_master #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH*8-1:0]   cmd_wdata,
   output logic                      rsp_valid,
   output logic                      rsp_write,
   output logic [DATA_WIDTH*8-1:0]   rsp_rdata,
   output logic                      rsp_error,
   output logic                      busy,
   output logic                      psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDR_WIDTH-1:0]     paddr,
   output logic [DATA_WIDTH*8-1:0]   pwdata,
   input  logic [DATA_WIDTH*8-1:0]   prdata,
   input  logic                      pslverr
);
   localparam int W  = DATA_WIDTH * 8;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [W-1:0]          wdata;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   cmd_t            mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   state_t          state;
   logic            push;
   logic            pop;
   cmd_t            head;

   assign cmd_ready = (count != CW'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   // A new transfer can start from IDLE or straight out of ACCESS (back-to-back).
   assign pop       = (count != '0) && ((state == IDLE) || (state == ACCESS));
   assign head      = mem[rd_ptr];
   assign busy      = (count != '0) || (state != IDLE);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_write <= 1'b0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               if (pop) begin
                  state  <= SETUP;
                  psel   <= 1'b1;
                  pwrite <= head.write;
                  paddr  <= head.addr;
                  pwdata <= head.write ? head.wdata : '0;
               end
            end
            SETUP: begin
               state   <= ACCESS;
               penable <= 1'b1;
            end
            ACCESS: begin
               rsp_valid <= 1'b1;
               rsp_write <= pwrite;
               rsp_rdata <= pwrite ? '0 : prdata;
               rsp_error <= pslverr;
               penable   <= 1'b0;
               if (pop) begin
                  state  <= SETUP;
                  pwrite <= head.write;
                  paddr  <= head.addr;
                  pwdata <= head.write ? head.wdata : '0;
               end else begin
                  state <= IDLE;
                  psel  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               psel    <= 1'b0;
               penable <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a behavioural register-file slave on the APB side and a
// queue-based transaction model predicting every bus, response and flow-control output.
module tb_apb_master;
   localparam int AW = 3;
   localparam int W  = 8;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [W-1:0]  cmd_wdata;
   logic          rsp_valid, rsp_write, rsp_error, busy;
   logic [W-1:0]  rsp_rdata;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [W-1:0]  pwdata, prdata;
   logic          pslverr;

   apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(1), .FIFO_DEPTH(D)) dut (
      .clk(clk), .n_rst(n_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .busy(busy),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   // Slave: address 0 is a read-only status register, the rest are plain storage.
   logic [W-1:0] smem [8];
   assign prdata  = (psel && !pwrite) ? ((paddr == 0) ? 8'h5A : smem[paddr]) : '0;
   assign pslverr = psel && pwrite && (paddr == 0);
   always @(posedge clk)
      if (psel && penable && pwrite && paddr != 0) smem[paddr] <= pwdata;

   typedef struct {bit w; bit [AW-1:0] a; bit [W-1:0] d;} mcmd_t;
   mcmd_t        q[$];
   mcmd_t        cur;
   int           left;          // bus cycles remaining in the current transfer
   bit [W-1:0]   ref_mem [8];
   bit           exp_rv, exp_rw, exp_re, last_push;
   bit [W-1:0]   exp_rd;
   int           exp_rsp_total, rsp_cnt, err_cnt;
   logic [W-1:0] last_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit [W-1:0] ref_read(input bit [AW-1:0] a);
      return (a == 0) ? 8'h5A : ref_mem[a];
   endfunction

   task automatic model_reset();
      q.delete();
      left   = 0;
      exp_rv = 0;
      last_push = 0;
   endtask

   // Advance the reference model by one rising edge, using the inputs held before it.
   task automatic model_edge();
      int  size;
      bit  do_pop;
      if (!n_rst) begin
         model_reset();
         return;
      end
      size      = q.size();
      last_push = cmd_valid && (size < D);
      exp_rv    = 0;
      if (left == 1) begin
         exp_rv = 1;
         exp_rw = cur.w;
         exp_rd = cur.w ? 8'h00 : ref_read(cur.a);
         exp_re = cur.w && (cur.a == 0);
         if (cur.w && cur.a != 0) ref_mem[cur.a] = cur.d;
         exp_rsp_total++;
      end
      do_pop = (size > 0) && (left <= 1);
      if (do_pop) begin
         cur  = q.pop_front();
         left = 2;
      end else if (left > 0) begin
         left--;
      end
      if (last_push) q.push_back('{w: cmd_write, a: cmd_addr, d: cmd_wdata});
   endtask

   task automatic cmp_outputs();
      check("psel", psel, left > 0);
      check("penable", penable, left == 1);
      if (left > 0) begin
         check("pwrite", pwrite, cur.w);
         check("paddr", paddr, cur.a);
         check("pwdata", pwdata, cur.w ? cur.d : 8'h00);
      end
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
         check("rsp_write", rsp_write, exp_rw);
         check("rsp_rdata", rsp_rdata, exp_rd);
         check("rsp_error", rsp_error, exp_re);
      end
      check("cmd_ready", cmd_ready, q.size() < D);
      check("busy", busy, (q.size() > 0) || (left > 0));
      if (rsp_valid) begin
         rsp_cnt++;
         last_rdata = rsp_rdata;
         if (rsp_error) err_cnt++;
      end
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_psel"}, psel, 0);
      check({tag, "_penable"}, penable, 0);
      check({tag, "_pwrite"}, pwrite, 0);
      check({tag, "_paddr"}, paddr, 0);
      check({tag, "_pwdata"}, pwdata, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_write"}, rsp_write, 0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 0);
      check({tag, "_rsp_error"}, rsp_error, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_cmd_ready"}, cmd_ready, 1);
   endtask

   // Called at a falling edge: drive, take one rising edge, then compare.
   task automatic cycle(input bit v, input bit w, input bit [AW-1:0] a, input bit [W-1:0] d);
      cmd_valid = v;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cmp_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   task automatic push_hold(input bit w, input bit [AW-1:0] a, input bit [W-1:0] d);
      int tries = 0;
      do begin
         cycle(1, w, a, d);
         tries++;
      end while (!last_push && tries < 20);
      if (!last_push) check("push_timeout", 0, 1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc;
      for (int i = 0; i < 8; i++) begin
         smem[i]    = '0;
         ref_mem[i] = '0;
      end
      exp_rsp_total = 0; rsp_cnt = 0; err_cnt = 0; last_rdata = '0;
      model_reset();

      n_rst = 0; cmd_valid = 1; cmd_write = 1; cmd_addr = 3'd5; cmd_wdata = 8'h77;
      @(negedge clk);
      @(negedge clk);
      chk_reset("rst");
      n_rst = 1;
      idle(4);

      // Divisor writes back-to-back, then check the slave registers.
      cycle(1, 1, 3'd2, 8'h0A);
      cycle(1, 1, 3'd3, 8'h00);
      idle(6);
      check("bitper_lo", smem[2], 8'h0A);
      check("bitper_hi", smem[3], 8'h00);

      // Divisor 1000 then read back the low byte.
      cycle(1, 1, 3'd2, 8'hE8);
      cycle(1, 1, 3'd3, 8'h03);
      cycle(1, 0, 3'd2, 8'hFF);
      idle(8);
      check("read_lo", last_rdata, 8'hE8);

      // Slave error must not block the following read.
      err_cnt = 0;
      cycle(1, 1, 3'd0, 8'hFF);
      cycle(1, 0, 3'd3, 8'h55);
      idle(8);
      check("err_cnt", err_cnt, 1);
      check("err_next_rd", last_rdata, 8'h03);

      // Saturate the FIFO so cmd_ready backpressure is exercised.
      for (int i = 0; i < 8; i++) push_hold(i[0], 3'(i + 1), 8'(8'h10 + i));
      idle(20);
      check("fill_rsp_cnt", rsp_cnt, exp_rsp_total);

      for (int i = 0; i < 400; i++) begin
         rc = $urandom_range(0, 3);
         cycle(rc != 0, $urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom));
      end
      idle(20);
      check("rand_rsp_cnt", rsp_cnt, exp_rsp_total);

      // Reset while in ACCESS with two commands still queued.
      cycle(1, 1, 3'd4, 8'hA1);
      cycle(1, 1, 3'd5, 8'hA2);
      cycle(1, 0, 3'd4, 8'h00);
      check("mid_setup", (left == 1) && (q.size() == 2), 1);
      cmd_valid = 0;
      #1 n_rst = 0;
      #1 chk_reset("midrst");
      model_reset();
      @(negedge clk);
      n_rst = 1;
      idle(8);
      check("midrst_rsp_cnt", rsp_cnt, exp_rsp_total);
      check("midrst_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
